// File: rtl/zx_pkg.sv
// zx_pkg: shared machine-mode constants, port decode masks and +3 special-paging table
package zx_pkg;
  localparam logic [1:0] MODE_48K  = 2'd0;
  localparam logic [1:0] MODE_128K = 2'd1;
  localparam logic [1:0] MODE_P3   = 2'd2;
  localparam logic [1:0] MODE_PENT = 2'd3;
  localparam logic [15:0] PORT7FFD_MASK     = 16'h8002;
  localparam logic [15:0] PORT7FFD_MATCH    = 16'h0000;
  localparam logic [15:0] PORT7FFD_P3_MASK  = 16'hC002;
  localparam logic [15:0] PORT7FFD_P3_MATCH = 16'h4000;
  localparam logic [15:0] PORT1FFD_MASK     = 16'hF002;
  localparam logic [15:0] PORT1FFD_MATCH    = 16'h1000;
  // indexed by {1ffd[2:1], slot}; element 0 is the rightmost entry
  localparam logic [15:0][2:0] SPECIAL_MAP = {
    3'd3, 3'd6, 3'd7, 3'd4,
    3'd3, 3'd6, 3'd5, 3'd4,
    3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0
  };
endpackage

// File: rtl/port_latch.sv
// port_latch: byte register committed once per I/O cycle on the first ce that sees its select
module port_latch (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       sel,
  input  logic       lock,
  input  logic [7:0] d,
  input  logic [7:0] mask,
  output logic [7:0] q
);
  logic wrd;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrd <= 1'b0;
      q <= 8'h00;
    end else if (ce) begin
      wrd <= sel;
      if (sel && !wrd && !lock) q <= d & mask;
    end
  end
endmodule

// File: rtl/paging_unit.sv
// paging_unit: 7FFD/1FFD port registers and CPU address to ROM/RAM page mapping
module paging_unit
  import zx_pkg::*;
#(
  parameter int RAM_PAGES_LOG2 = 5,
  parameter int ROM_PAGES_LOG2 = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [1:0]                mode,
  input  logic                      iorq,
  input  logic                      wr,
  input  logic [15:0]               a,
  input  logic [7:0]                d,
  output logic [RAM_PAGES_LOG2+14:0] mem_a,
  output logic                      is_ram,
  output logic                      writable,
  output logic                      contended,
  output logic                      vid_page,
  output logic                      locked,
  output logic [7:0]                port7ffd,
  output logic [7:0]                port1ffd
);
  logic [7:0] q7, q1, mask7;
  logic sel7, sel1, io_wr, special;
  logic [4:0] ram_pg, pv;
  logic [1:0] rom_pg;
  logic [ROM_PAGES_LOG2-1:0] rom_t;
  logic [RAM_PAGES_LOG2-1:0] pg;
  port_latch u_7ffd (
    .clock(clock), .reset(reset), .ce(ce), .sel(sel7), .lock(q7[5]),
    .d(d), .mask(mask7), .q(q7)
  );
  port_latch u_1ffd (
    .clock(clock), .reset(reset), .ce(ce), .sel(sel1), .lock(q7[5]),
    .d(d), .mask(8'h07), .q(q1)
  );
  always_comb begin
    io_wr = !iorq && !wr;
    // the extra Pentagon page bits only exist when there is RAM for them to address
    mask7 = (mode == MODE_PENT && RAM_PAGES_LOG2 > 3) ? 8'hFF : 8'h3F;
    sel7 = io_wr && ((mode == MODE_128K || mode == MODE_PENT) ? (a & PORT7FFD_MASK) == PORT7FFD_MATCH :
                     mode == MODE_P3 && (a & PORT7FFD_P3_MASK) == PORT7FFD_P3_MATCH);
    sel1 = io_wr && mode == MODE_P3 && (a & PORT1FFD_MASK) == PORT1FFD_MATCH;
    special = mode == MODE_P3 && q1[0];
    rom_pg = mode == MODE_48K ? 2'd0 : {mode == MODE_P3 && q1[2], q7[4]};
    rom_t = ROM_PAGES_LOG2'(rom_pg);
    ram_pg = special ? 5'(SPECIAL_MAP[{q1[2:1], a[15:14]}]) :
             a[15:14] == 2'b01 ? 5'd5 :
             a[15:14] == 2'b10 ? 5'd2 :
             mode == MODE_48K ? 5'd0 :
             mode == MODE_PENT ? {q7[7:6], q7[2:0]} : {2'b00, q7[2:0]};
    is_ram = special || a[15:14] != 2'b00;
    pg = is_ram ? RAM_PAGES_LOG2'(ram_pg) : RAM_PAGES_LOG2'(rom_t);
    pv = 5'(pg);
    contended = is_ram && (mode == MODE_P3 ? (pv >= 5'd4 && pv <= 5'd7) : (pv[0] && pv < 5'd8));
  end
  assign mem_a = {is_ram, pg, a[13:0]};
  assign writable = is_ram;
  assign vid_page = mode != MODE_48K && q7[3];
  assign locked = q7[5];
  assign port7ffd = q7;
  assign port1ffd = q1;
endmodule

// File: doc/paging_unit.md
Name: paging_unit

Overview:
- Parametrised successor to the fixed 48K/128K paging logic in the machine top level.
- Decodes CPU port writes to 7FFD, 1FFD (+3) and the Pentagon extension bits, and holds the paging registers and lock state.
- Maps every CPU address to a ROM or RAM page, and flags contended pages and the active shadow screen.
- Sits between the CPU bus and the SDRAM/BRAM address mux.
- The esxDOS mapper overrides its ROM output externally.

Parameters:
- RAM_PAGES_LOG2, 5, log2 of the number of 16K RAM pages; legal range 3..5 (128K..512K).
- ROM_PAGES_LOG2, 2, log2 of the number of 16K ROM pages; legal range 1..2.

Ports:
- clock  in  1  system clock (56 MHz).
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  CPU clock-enable, rising phase (contention-gated).
- mode  in  2  0 = 48K, 1 = 128K, 2 = +2A/+3, 3 = Pentagon.
- iorq  in  1  CPU IORQ, active low.
- wr  in  1  CPU WR, active low.
- a  in  16  CPU address.
- d  in  8  CPU data out.
- mem_a  out  RAM_PAGES_LOG2+15  {is_ram, page zero-extended to RAM_PAGES_LOG2, a[13:0]}.
- is_ram  out  1  current address maps to RAM.
- writable  out  1  1 when is_ram.
- contended  out  1  current address lies in a contended RAM page.
- vid_page  out  1  0 = screen in page 5, 1 = page 7.
- locked  out  1  7FFD bit 5 latched.
- port7ffd  out  8  register readback.
- port1ffd  out  8  register readback.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high.
- Reset values: port7ffd = 0x00, port1ffd = 0x00, locked = 0, strobe history = inactive.
  - Post-reset outputs (a = 0): is_ram = 0, mem_a = 0, vid_page = 0.
- Port decode (combinational, qualified by !iorq && !wr):
  - sel7ffd, mode 1 or 3: !a[15] && !a[1].
  - sel7ffd, mode 2: a[15:14] = 01 && !a[1].
  - sel1ffd, mode 2 only: a[15:12] = 0001 && !a[1].
  - Mode 0: no selects.
- Write commit:
  - On each ce, register the select state (wrd7, wrd1).
  - A select that is active now and was inactive at the previous ce commits d on that ce.
  - Only one commit per I/O cycle, however many ce the cycle spans.
- Lock:
  - While locked = 1, writes to both ports are ignored.
  - Only reset clears the lock.
  - A write setting bit 5 is itself accepted, and locks from the next access.
- Register width:
  - Pentagon: port7ffd[7:6] are stored only when RAM_PAGES_LOG2 > 3, else forced to 0.
  - port1ffd stores bits [2:0]; bits [7:3] read as 0.
- Latency: new mapping is visible on combinational outputs the clock after the committing ce.
- Normal paging (port1ffd[0] = 0, or mode != 2):
  - a[15:14] = 00 → ROM.
    - Mode 0: ROM page 0.
    - Modes 1 and 3: ROM page {0, 7ffd[4]}.
    - Mode 2: ROM page {1ffd[2], 7ffd[4]}, truncated to ROM_PAGES_LOG2.
  - 01 → RAM page 5.
  - 10 → RAM page 2.
  - 11 → RAM page as follows:
    - Mode 0: page 0.
    - Modes 1 and 2: 7ffd[2:0].
    - Mode 3: {7ffd[7:6], 7ffd[2:0]}, truncated to RAM_PAGES_LOG2.
- Special paging (mode 2, 1ffd[0] = 1): the four slots use RAM pages chosen by 1ffd[2:1]:
  - 00 → 0,1,2,3.
  - 01 → 4,5,6,7.
  - 10 → 4,5,6,3.
  - 11 → 4,7,6,3.
  - No ROM is mapped.
- Contended:
  - Set only when is_ram.
  - Modes 0, 1, 3: page[0] = 1 and page < 8, i.e. pages 1, 3, 5, 7.
  - Mode 2: page in 4..7.
- vid_page = 7ffd[3] in modes 1–3; 0 in mode 0.
- Mode change mid-run: registers retain their values; only decoding and mapping change.
- Reset asserted mid-write: registers clear immediately; a pending commit is lost.

Decomposition:
- Shared package zx_pkg holds:
  - Mode constants MODE_48K, MODE_128K, MODE_P3, MODE_PENT.
  - The special-paging table as a constant array.
  - Port address masks.
- One natural sub-module: port_latch, an edge-detected, ce-qualified, lock-gated byte register instanced twice.
- Mapping stays combinational in the parent.

Test Plan:
- Mode 1: OUT 7FFD,0x13 → a = C000 gives mem_a page 3, contended = 1, ROM page 1.
  - Then OUT 7FFD,0x20 followed by OUT 7FFD,0x07 → second write ignored, locked = 1, page stays 0.
- Mode 3, RAM_PAGES_LOG2 = 5: OUT 7FFD,0xC6 → a = C000 maps to page 30, contended = 0.
  - Same write with RAM_PAGES_LOG2 = 3 → page 6, port7ffd readback = 0x06.
- Mode 2: OUT 1FFD,0x07 → a = 0000 maps to RAM page 4, a = 4000 to page 7, contended = 1.
  - Then OUT 1FFD,0x04 with 7ffd[4] = 1 → ROM page 3.
- I/O cycle held across 4 ce with d changing 0x01→0x02 mid-cycle → only 0x01 committed.
- Mode 0: OUT 7FFD,0x07 → no change; a = C000 gives page 0; vid_page = 0.
- Reset pulse between ce while locked → all registers 0, locked = 0, next 7FFD write accepted.
